mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single shared data memory.
// Optional m1 grant locking is enabled by defining MEM_ARBITER_LOCK_EN.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [3:0]    m0_wmask,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_wmask,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [3:0]    mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic last_gnt;
    logic rd_v;
    logic rd_idx;
    logic g0;
    logic g1;
    logic locked;
    logic m0_rd;
    logic m1_rd;

    // Low address bits select a byte lane only; memory is word addressed.
    logic [3:0] unused_bits;
    assign unused_bits = {m0_addr[1:0], m1_addr[1:0]};

`ifdef MEM_ARBITER_LOCK_EN
    logic lock_q;
    assign locked = lock_q;

    // Lock is held while m1 keeps requesting with m1_lock set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else if (!m1_req) begin
            lock_q <= 1'b0;
        end else if (g1) begin
            lock_q <= m1_lock;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = m1_lock;
    assign locked = 1'b0;
`endif

    // Grant decision: lock first, then round-robin on contention.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset) begin
            if (locked) begin
                g1 = m1_req;
            end else if (m0_req && m1_req) begin
                g0 = last_gnt;
                g1 = !last_gnt;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
    end

    assign m0_gnt = g0;
    assign m1_gnt = g1;
    assign m0_rd  = g0 && (m0_wmask == 4'b0000);
    assign m1_rd  = g1 && (m1_wmask == 4'b0000);

    // Steer the granted requester onto the memory port.
    always_comb begin
        mem_wmask = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (g0) begin
            mem_wmask = m0_wmask;
            mem_addr  = {m0_addr[AW-1:2], 2'b00};
            mem_wdata = m0_wdata;
        end else if (g1) begin
            mem_wmask = m1_wmask;
            mem_addr  = {m1_addr[AW-1:2], 2'b00};
            mem_wdata = m1_wdata;
        end
    end

    // Round-robin pointer and owner of the read returning next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= 1'b1;
            rd_v     <= 1'b0;
            rd_idx   <= 1'b0;
        end else begin
            if (g0 || g1) begin
                last_gnt <= g1;
            end
            rd_v   <= m0_rd || m1_rd;
            rd_idx <= m1_rd;
        end
    end

    assign m0_rvalid = rd_v && !rd_idx;
    assign m1_rvalid = rd_v && rd_idx;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory model and read scoreboard.
// Honours MEM_ARBITER_LOCK_EN the same way as the design.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m1_lock;
    logic [3:0]  m0_wmask, m1_wmask;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(rst_n),
        .m0_req(m0_req), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [0:255];
    logic [31:0] refmem [0:255];

    // Shared memory: byte-masked write, registered read.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b])
                mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    typedef struct {
        int          cyc;
        bit          idx;
        logic [31:0] data;
    } rd_t;

    rd_t sb[$];
    int  nchk = 0;
    int  nerr = 0;
    int  cycle = 0;
    bit  lg = 1'b1;
    bit  lk_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic cyc(input logic r0, input logic [3:0] w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk);
        logic        e0, e1, ev0, ev1;
        logic [31:0] ed0, ed1, ea, ed;
        logic [3:0]  em;
        rd_t         ent;
        m0_req = r0; m0_wmask = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_wmask = w1; m1_addr = a1; m1_wdata = d1;
        m1_lock = lk;
        @(negedge clk);
        e0 = 1'b0; e1 = 1'b0;
        if (rst_n) begin
            if (lk_m) e1 = r1;
            else if (r0 && r1) begin e0 = lg; e1 = !lg; end
            else begin e0 = r0; e1 = r1; end
        end
        chk("gnt0", {31'd0, m0_gnt}, {31'd0, e0});
        chk("gnt1", {31'd0, m1_gnt}, {31'd0, e1});
        em = 4'b0; ea = 32'd0; ed = 32'd0;
        if (e0) begin em = w0; ea = {a0[31:2], 2'b00}; ed = d0; end
        if (e1) begin em = w1; ea = {a1[31:2], 2'b00}; ed = d1; end
        chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, em});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        if (!rst_n) sb.delete();
        ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'd0; ed1 = 32'd0;
        if (sb.size() > 0 && sb[0].cyc == cycle - 1) begin
            ent = sb.pop_front();
            if (ent.idx) begin ev1 = 1'b1; ed1 = ent.data; end
            else begin ev0 = 1'b1; ed0 = ent.data; end
        end
        chk("rvalid0", {31'd0, m0_rvalid}, {31'd0, ev0});
        chk("rvalid1", {31'd0, m1_rvalid}, {31'd0, ev1});
        chk("rdata0", m0_rdata, ed0);
        chk("rdata1", m1_rdata, ed1);
        if (!rst_n) begin
            lg = 1'b1;
            lk_m = 1'b0;
        end else begin
            if (e0 || e1) lg = e1;
            if (e0 && w0 == 4'b0)
                sb.push_back('{cycle, 1'b0, refmem[a0[9:2]]});
            if (e1 && w1 == 4'b0)
                sb.push_back('{cycle, 1'b1, refmem[a1[9:2]]});
            if (e0 && w0 != 4'b0)
                refmem[a0[9:2]] = merge(refmem[a0[9:2]], d0, w0);
            if (e1 && w1 != 4'b0)
                refmem[a1[9:2]] = merge(refmem[a1[9:2]], d1, w1);
`ifdef MEM_ARBITER_LOCK_EN
            if (!r1) lk_m = 1'b0;
            else if (e1) lk_m = lk;
`endif
        end
        cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = i * 32'h01010101;
            refmem[i] = i * 32'h01010101;
        end
        mem[64] = 32'hDEADBEEF; refmem[64] = 32'hDEADBEEF;
        mem[16] = 32'hAABBCCDD; refmem[16] = 32'hAABBCCDD;
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0; m1_lock = 0;
        m0_wmask = 0; m1_wmask = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        #1;
        // requests under reset must be ignored
        cyc(1, 4'h0, 32'h100, 32'h0, 1, 4'hF, 32'h40, 32'h55, 0);
        cyc(1, 4'h0, 32'h100, 32'h0, 1, 4'hF, 32'h40, 32'h55, 0);
        rst_n = 1'b1;
        // m0 alone reads 0x100
        cyc(1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        idle();
        // fresh reset, both request every cycle
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc(1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h44, 32'h0, 0);
        idle();
        // partial write by m1 then read back by m0
        cyc(0, 4'h0, 32'h0, 32'h0, 1, 4'b0011, 32'h40, 32'h12345678, 0);
        cyc(1, 4'h0, 32'h40, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        idle();
        chk("req034", refmem[16], 32'hAABB5678);
        // read in flight killed by reset
        cyc(1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        rst_n = 1'b0;
        cyc(1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        rst_n = 1'b1;
        cyc(1, 4'h0, 32'h48, 32'h0, 1, 4'h0, 32'h4C, 32'h0, 0);
        idle();
        // m1 lock burst while m0 keeps requesting
        cyc(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20 + i*4, 32'h0, 1);
        cyc(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        idle();
        // lock released by an m1 grant with lock low
        cyc(1, 4'h0, 32'h14, 32'h0, 1, 4'h0, 32'h30, 32'h0, 1);
        cyc(1, 4'h0, 32'h14, 32'h0, 1, 4'h0, 32'h34, 32'h0, 0);
        cyc(1, 4'h0, 32'h14, 32'h0, 1, 4'h0, 32'h38, 32'h0, 0);
        idle();
        // write/read contention on one address, then back-to-back reads
        cyc(1, 4'hF, 32'h80, 32'hCAFEF00D, 1, 4'h0, 32'h80, 32'h0, 0);
        cyc(1, 4'hF, 32'h80, 32'hCAFEF00D, 1, 4'h0, 32'h80, 32'h0, 0);
        cyc(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h84, 32'h0, 0);
        cyc(0, 4'h0, 32'h0, 32'h0, 1, 4'b1100, 32'h88, 32'h99887766, 0);
        cyc(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h88, 32'h0, 0);
        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
